// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the CPU54 control unit and seq_divider.
// The control unit is the master. It drives the request and the operands.
// The divider is the slave. It returns the quotient, the remainder and the status flags.
interface seq_divider_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;

    modport master (
        output start, is_signed, dividend, divisor,
        input  q, r, busy, done
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output q, r, busy, done
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// The result loads LO (q) and HI (r).
//
// state | meaning
// IDLE  | waiting for start; q/r hold the last result
// RUN   | 32 restoring steps, one per cycle
// FIX   | apply signs / divide-by-zero result, write q/r, pulse done
module seq_divider (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // The partial remainder is always below the divisor magnitude, so 32 stored bits suffice.
    // The 33rd bit appears only in the shifted trial value.
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;      // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] dvs_q, dvs_d;      // divisor magnitude
    logic [31:0] orig_q, orig_d;    // raw dividend, returned as r on divide-by-zero
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        div0_q, div0_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic        done_q, done_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] shift_w, trial_w;

    assign a_mag   = (bus.is_signed && bus.dividend[31]) ? (~bus.dividend + 32'd1) : bus.dividend;
    assign b_mag   = (bus.is_signed && bus.divisor[31])  ? (~bus.divisor + 32'd1)  : bus.divisor;
    assign shift_w = {rem_q, quo_q[31]};
    assign trial_w = shift_w - {1'b0, dvs_q};

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.done = done_q;
    assign bus.busy = (state_q != IDLE);

    // Next-state, datapath step and result write-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        div0_d  = div0_q;
        q_d     = q_q;
        r_d     = r_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    orig_d  = bus.dividend;
                    q_neg_d = bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
                    r_neg_d = bus.is_signed & bus.dividend[31];
                    div0_d  = (bus.divisor == 32'd0);
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!trial_w[32]) begin
                    rem_d = trial_w[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shift_w[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div0_q) begin
                    q_d = 32'hFFFF_FFFF;
                    r_d = orig_q;
                end else begin
                    q_d = q_neg_q ? (~quo_q + 32'd1) : quo_q;
                    r_d = r_neg_q ? (~rem_q + 32'd1) : rem_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            orig_q  <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            div0_q  <= 1'b0;
            q_q     <= 32'd0;
            r_q     <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            div0_q  <= div0_d;
            q_q     <= q_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end
endmodule
